// File: rtl/int_dispatch_queue_pkg.sv
// Payload types shared by the integer dispatch queue, its interface and its bench.
package int_dispatch_queue_pkg;

  typedef struct packed {
    logic [7:0]  rob_idx;
    logic [5:0]  irob_idx;
    logic [17:0] uop;
  } intDQEntry_t;

endpackage

// File: rtl/int_dispatch_queue_if.sv
// Rename-side enqueue and issue-side dequeue bundle for int_dispatch_queue.
// perf_full_cyc exists only when INT_DQ_PERF_EN is defined.
interface int_dispatch_queue_if
  import int_dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned INPORTS  = 4,
  parameter int unsigned OUTPORTS = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                               squash;
  logic                               can_enq;
  logic        [INPORTS-1:0]          enq_req;
  intDQEntry_t [INPORTS-1:0]          enq_data;
  logic        [OUTPORTS-1:0]         deq_vld;
  intDQEntry_t [OUTPORTS-1:0]         deq_data;
  logic        [OUTPORTS-1:0]         deq_rdy;
  logic        [CW-1:0]               count;
`ifdef INT_DQ_PERF_EN
  logic        [31:0]                 perf_full_cyc;

  modport master (output squash, enq_req, enq_data, deq_rdy,
                  input  can_enq, deq_vld, deq_data, count, perf_full_cyc);
  modport slave  (input  squash, enq_req, enq_data, deq_rdy,
                  output can_enq, deq_vld, deq_data, count, perf_full_cyc);
`else
  modport master (output squash, enq_req, enq_data, deq_rdy,
                  input  can_enq, deq_vld, deq_data, count);
  modport slave  (input  squash, enq_req, enq_data, deq_rdy,
                  output can_enq, deq_vld, deq_data, count);
`endif

endinterface

// File: rtl/int_dispatch_queue.sv
// In-order circular dispatch queue between rename and the integer issue queues.
// Optional full-stall perf counter enabled by defining INT_DQ_PERF_EN.
module int_dispatch_queue
  import int_dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned INPORTS  = 4,
  parameter int unsigned OUTPORTS = 4
)(
  input  logic               clk,
  input  logic               rst,
  int_dispatch_queue_if.slave dq
);
  localparam int unsigned       PW        = $clog2(DEPTH);
  localparam int unsigned       CW        = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]     INPORTS_C = CW'(INPORTS);

  intDQEntry_t   mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_next, nenq, ndeq;
  logic [PW-1:0] offset [INPORTS];
  logic          can_enq_c, enq_fire, run;

  assign can_enq_c = (DEPTH_C - count) >= INPORTS_C;
  assign enq_fire  = can_enq_c && (|dq.enq_req) && !dq.squash;

  // Compact sparse requests: each requesting port lands at tail + (#requests before it).
  always_comb begin
    nenq = '0;
    for (int i = 0; i < INPORTS; i++) begin
      offset[i] = PW'(nenq);
      if (dq.enq_req[i]) nenq = nenq + CW'(1);
    end
  end

  // Only the unbroken run of accepted slots from the oldest one leaves the queue.
  always_comb begin
    ndeq = '0;
    run  = 1'b1;
    for (int k = 0; k < OUTPORTS; k++) begin
      run = run & dq.deq_vld[k] & dq.deq_rdy[k];
      if (run) ndeq = ndeq + CW'(1);
    end
  end

  always_comb begin
    for (int k = 0; k < OUTPORTS; k++) begin
      dq.deq_vld[k]  = CW'(k) < count;
      dq.deq_data[k] = mem[head + PW'(k)];
    end
  end

  assign count_next = count + (enq_fire ? nenq : CW'(0)) - ndeq;
  assign dq.count   = count;
  assign dq.can_enq = can_enq_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (dq.squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(ndeq);
      if (enq_fire) tail <= tail + PW'(nenq);
      count <= count_next;
    end
  end

  // Payload storage is deliberately left unreset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < INPORTS; i++) begin
        if (dq.enq_req[i]) mem[tail + offset[i]] <= dq.enq_data[i];
      end
    end
  end

`ifdef INT_DQ_PERF_EN
  logic [31:0] perf_full_cyc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_full_cyc <= '0;
    end else if ((|dq.enq_req) && !can_enq_c && (perf_full_cyc != 32'hFFFF_FFFF)) begin
      perf_full_cyc <= perf_full_cyc + 32'd1;
    end
  end

  assign dq.perf_full_cyc = perf_full_cyc;
`endif

  a_count_max: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);
  a_ptr_count: assert property (@(posedge clk) disable iff (rst)
                                PW'(tail - head) == PW'(count));
  a_enq_proto: assert property (@(posedge clk) disable iff (rst)
                                !((|dq.enq_req) && !can_enq_c))
    else $warning("int_dispatch_queue: enq_req while can_enq=0, request dropped");

endmodule

// File: tb/tb_int_dispatch_queue.sv
// Scoreboard bench for int_dispatch_queue: a queue model fed by the stimulus, drained by a monitor.
module tb_int_dispatch_queue;
  import int_dispatch_queue_pkg::*;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned INPORTS  = 4;
  localparam int unsigned OUTPORTS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int_dispatch_queue_if #(.DEPTH(DEPTH), .INPORTS(INPORTS), .OUTPORTS(OUTPORTS)) dq ();

  int_dispatch_queue #(.DEPTH(DEPTH), .INPORTS(INPORTS), .OUTPORTS(OUTPORTS)) dut (
    .clk (clk),
    .rst (rst),
    .dq  (dq.slave)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned seq         = 0;
  intDQEntry_t exp_q[$];
  intDQEntry_t pend[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic intDQEntry_t mk(input int unsigned rob);
    intDQEntry_t e;
    e.rob_idx  = 8'(rob);
    e.irob_idx = 6'($urandom);
    e.uop      = 18'($urandom);
    return e;
  endfunction

  // Drive one cycle; accepted uops join the model at the edge that writes them.
  task automatic apply(input logic [3:0] req, input logic [3:0] rdy, input logic sq);
    bit acc;
    acc = (req != 4'b0) && !sq && ((DEPTH - exp_q.size()) >= INPORTS);
    for (int i = 0; i < INPORTS; i++) begin
      dq.enq_data[i] = mk(seq);
      if (req[i] && acc) begin
        pend.push_back(dq.enq_data[i]);
        seq++;
      end
    end
    dq.enq_req = req;
    dq.deq_rdy = rdy;
    dq.squash  = sq;
    @(posedge clk);
    #1;
    if (sq) exp_q.delete();
    else foreach (pend[j]) exp_q.push_back(pend[j]);
    pend.delete();
  endtask

  // Monitor: compare presented outputs against the model, then retire what the consumer took.
  initial begin
    int         n, nd;
    bit         take;
    logic [3:0] ev;
    forever begin
      @(negedge clk);
      if (!rst) begin
        n = exp_q.size();
        chk("count", 64'(dq.count), 64'(n));
        chk("can_enq", 64'(dq.can_enq), 64'((DEPTH - n) >= INPORTS));
        for (int k = 0; k < OUTPORTS; k++) ev[k] = (k < n);
        chk("deq_vld", 64'(dq.deq_vld), 64'(ev));
        for (int k = 0; k < OUTPORTS; k++) begin
          if (k < n) chk($sformatf("deq_data[%0d]", k), 64'(dq.deq_data[k]), 64'(exp_q[k]));
        end
        if (!dq.squash) begin
          take = 1'b1;
          nd   = 0;
          for (int k = 0; k < OUTPORTS; k++) begin
            take = take && (k < n) && dq.deq_rdy[k];
            if (take) nd++;
          end
          repeat (nd) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] r;
`ifdef INT_DQ_PERF_EN
    logic [31:0] perf0;
`endif
    dq.squash   = 1'b0;
    dq.enq_req  = '0;
    dq.deq_rdy  = '0;
    dq.enq_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset count", 64'(dq.count), 64'd0);
    chk("reset deq_vld", 64'(dq.deq_vld), 64'd0);
    chk("reset can_enq", 64'(dq.can_enq), 64'd1);

    // Dense then sparse enqueue; rob_idx 0..3 then 4,5.
    apply(4'b1111, 4'b0000, 1'b0);
    apply(4'b1010, 4'b0000, 1'b0);
    chk("count after 6", 64'(dq.count), 64'd6);
    for (int k = 0; k < OUTPORTS; k++)
      chk($sformatf("rob_idx slot %0d", k), 64'(dq.deq_data[k].rob_idx), 64'(k));

    // Fill to 16, then hammer while full.
    apply(4'b0011, 4'b0000, 1'b0);
    apply(4'b1111, 4'b0000, 1'b0);
    apply(4'b1111, 4'b0000, 1'b0);
    chk("full count", 64'(dq.count), 64'd16);
    chk("full can_enq", 64'(dq.can_enq), 64'd0);
`ifdef INT_DQ_PERF_EN
    perf0 = dq.perf_full_cyc;
    chk("perf before stall", 64'(perf0), 64'd0);
`endif
    repeat (3) apply(4'b1111, 4'b0000, 1'b0);
    chk("count after rejected enq", 64'(dq.count), 64'd16);
`ifdef INT_DQ_PERF_EN
    chk("perf after stall", 64'(dq.perf_full_cyc), 64'd3);
`endif

    // Drain to 4 (rob 12..15), then a gapped ready mask retires only two.
    repeat (3) apply(4'b0000, 4'b1111, 1'b0);
    apply(4'b0000, 4'b1011, 1'b0);
    chk("ndeq=2 count", 64'(dq.count), 64'd2);
    chk("ndeq=2 head rob", 64'(dq.deq_data[0].rob_idx), 64'd14);

    // Random traffic across many pointer wraps.
    repeat (300) begin
      r = ((DEPTH - exp_q.size()) >= INPORTS) ? 4'($urandom) : 4'b0000;
      apply(r, 4'($urandom), 1'b0);
    end

    for (int c = 0; c < 40 && exp_q.size() != 0; c++) apply(4'b0000, 4'b1111, 1'b0);
    chk("drained", 64'(exp_q.size()), 64'd0);

    // Squash beats a same-cycle enqueue and dequeue.
    apply(4'b1111, 4'b0000, 1'b0);
    apply(4'b1111, 4'b0000, 1'b0);
    apply(4'b0011, 4'b0000, 1'b0);
    chk("pre-squash count", 64'(dq.count), 64'd10);
    apply(4'b1111, 4'b1111, 1'b1);
    chk("squash count", 64'(dq.count), 64'd0);
    chk("squash deq_vld", 64'(dq.deq_vld), 64'd0);
    chk("squash can_enq", 64'(dq.can_enq), 64'd1);
`ifdef INT_DQ_PERF_EN
    chk("perf kept over squash", 64'(dq.perf_full_cyc), 64'd3);
`endif

    // Asynchronous reset mid-operation empties the queue at once.
    apply(4'b1111, 4'b0001, 1'b0);
    apply(4'b1111, 4'b0001, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("async rst count", 64'(dq.count), 64'd0);
    chk("async rst deq_vld", 64'(dq.deq_vld), 64'd0);
    exp_q.delete();
`ifdef INT_DQ_PERF_EN
    chk("perf cleared by rst", 64'(dq.perf_full_cyc), 64'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    apply(4'b0110, 4'b0000, 1'b0);
    apply(4'b0000, 4'b0001, 1'b0);
    apply(4'b0000, 4'b0000, 1'b0);

    dq.enq_req = '0;
    dq.deq_rdy = '0;
    dq.squash  = 1'b0;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
